// File: rtl/seq_restoring_divider_if.sv
// Operand/result bus for the sequential restoring divider.
// Handshake: a transfer happens on a rising edge where valid && ready; the producer
// holds valid and its data stable until that edge and never waits for ready first.
interface seq_restoring_divider_if #(parameter int N = 32);
   logic           in_valid;
   logic           in_ready;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] quotient;
   logic [N-1:0]   remainder;
   logic           div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Results sit in dedicated output registers so they stay put outside the DONE window.
module seq_restoring_divider #(
   parameter int N = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   seq_restoring_divider_if.slave bus,
   output logic [1:0]            dbg_state
);
   localparam int            CW   = $clog2(2 * N);
   localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    d_q, d_d;
   logic [2*N-1:0]  q_q, q_d;
   logic [N:0]      r_q, r_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*N-1:0]  quot_q, quot_d;
   logic [N-1:0]    rem_q, rem_d;
   logic            dbz_q, dbz_d;

   logic [N:0]      trial;
   logic [N:0]      diff;
   logic            fits;
   logic            accept;

   assign accept = bus.in_valid && (state_q == S_IDLE);
   assign trial  = {r_q[N-1:0], q_q[2*N-1]};
   assign diff   = trial - {1'b0, d_q};
   assign fits   = (trial >= {1'b0, d_q});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         d_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = (bus.divisor == '0) ? S_DONE : S_CALC;
         S_CALC: if (cnt_q == LAST) state_d = S_DONE;
         S_DONE: if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Zero divisor bypasses the iteration and loads the saturated result directly.
   always_comb begin
      d_d    = d_q;
      q_d    = q_q;
      r_d    = r_q;
      cnt_d  = cnt_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      if (accept) begin
         d_d   = bus.divisor;
         q_d   = bus.dividend;
         r_d   = '0;
         cnt_d = '0;
         dbz_d = 1'b0;
         if (bus.divisor == '0) begin
            quot_d = '1;
            rem_d  = bus.dividend[N-1:0];
            dbz_d  = 1'b1;
         end
      end else if (state_q == S_CALC) begin
         r_d   = fits ? diff : trial;
         q_d   = {q_q[2*N-2:0], fits};
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == LAST) begin
            quot_d = q_d;
            rem_d  = r_d[N-1:0];
         end
      end
   end

   always_comb begin
      bus.in_ready    = (state_q == S_IDLE);
      bus.out_valid   = (state_q == S_DONE);
      bus.quotient    = quot_q;
      bus.remainder   = rem_q;
      bus.div_by_zero = dbz_q;
      dbg_state       = state_q;
   end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed cases plus a randomized run against an
// arithmetic reference, results checked by an independent monitor.
module tb_seq_restoring_divider;
   localparam int N = 32;
   localparam int W = 3 * N + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;

   seq_restoring_divider_if #(.N(N)) bus ();

   seq_restoring_divider #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           cmp_cnt = 0;
   int           err_cnt = 0;
   bit           rand_ready = 1'b0;

   // Packed as {div_by_zero, quotient, remainder}.
   function automatic logic [W-1:0] model(input logic [2*N-1:0] a, input logic [N-1:0] b);
      logic [2*N-1:0] bb;
      logic [2*N-1:0] qq;
      logic [2*N-1:0] rr;
      if (b == '0) return {1'b1, {(2*N){1'b1}}, a[N-1:0]};
      bb = {{N{1'b0}}, b};
      qq = a / bb;
      rr = a % bb;
      return {1'b0, qq, rr[N-1:0]};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL unexpected_result: got %h expected none",
                     {bus.div_by_zero, bus.quotient, bus.remainder});
         end else begin
            check("result", {bus.div_by_zero, bus.quotient, bus.remainder}, exp_q.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [2*N-1:0] a, input logic [N-1:0] b);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(negedge clk);
      while (!bus.in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", W'(0), W'(1));
         bus.in_valid = 1'b0;
         return;
      end
      exp_q.push_back(model(a, b));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.dividend = {$urandom(), $urandom()};
      bus.divisor  = $urandom();
   endtask

   // Counts rising edges after the accept edge until out_valid is seen.
   task automatic wait_valid(output int k);
      k = 0;
      @(negedge clk);
      while (!bus.out_valid && k < 200) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int k;
      int n;
      logic [2*N-1:0] a;
      logic [N-1:0]   b;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  W'(bus.in_ready),    W'(1));
      check("rst_out_valid", W'(bus.out_valid),   W'(0));
      check("rst_outputs",   {bus.div_by_zero, bus.quotient, bus.remainder}, W'(0));
      check("rst_state",     W'(dbg_state),       W'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      bus.out_ready = 1'b1;
      issue(64'd100, 32'd7);
      wait_valid(k);
      check("lat_basic", W'(k), W'(2 * N));
      @(posedge clk); #1;

      issue(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
      wait_valid(k);
      check("lat_max", W'(k), W'(2 * N));
      @(posedge clk); #1;

      issue(64'h1234_5678_9ABC_DEF0, 32'd1);
      wait_valid(k);
      check("lat_div1", W'(k), W'(2 * N));
      @(posedge clk); #1;

      issue(64'h1234, 32'd0);
      wait_valid(k);
      check("lat_div0", W'(k), W'(0));
      @(posedge clk); #1;

      // Backpressure: result must hold and a new request must be ignored.
      bus.out_ready = 1'b0;
      issue(64'd100, 32'd7);
      wait_valid(k);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin
            bus.in_valid = 1'b1;
            bus.dividend = 64'd55;
            bus.divisor  = 32'd5;
         end
         if (i == 7) bus.in_valid = 1'b0;
         @(negedge clk);
         check("bp_out_valid", W'(bus.out_valid), W'(1));
         check("bp_in_ready",  W'(bus.in_ready),  W'(0));
         check("bp_hold", {bus.div_by_zero, bus.quotient, bus.remainder}, {1'b0, 64'd14, 32'd2});
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_in_ready",  W'(bus.in_ready),  W'(1));
      check("bp_release_out_valid", W'(bus.out_valid), W'(0));
      @(posedge clk); #1;

      // Reset in the middle of the iteration discards the operation.
      issue(64'd5000, 32'd3);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready",  W'(bus.in_ready),  W'(1));
      check("midrst_out_valid", W'(bus.out_valid), W'(0));
      check("midrst_outputs", {bus.div_by_zero, bus.quotient, bus.remainder}, W'(0));
      repeat (70) @(posedge clk);
      #1;
      issue(64'd1000, 32'd10);
      wait_valid(k);
      check("lat_after_rst", W'(k), W'(2 * N));
      @(posedge clk); #1;

      // Randomized back-to-back run with random output stalls.
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         a = {$urandom(), $urandom()};
         b = $urandom();
         case ($urandom_range(0, 9))
            0: b = '0;
            1: b = N'($urandom_range(1, 15));
            2: a = {32'd0, $urandom()};
            default: ;
         endcase
         issue(a, b);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("drain", W'(exp_q.size()), W'(0));
      rand_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
